// File: rtl/lock_seq_ctrl.sv
// Keypad lock sequencer: collects 4-digit codes, unlocks on a match, supports
// reprogramming while unlocked, and locks the keypad out after repeated failures.
module lock_seq_ctrl #(
  parameter logic [15:0] DEF_CODE    = 16'h3695,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCKOUT_CYC = 1000,
  parameter int unsigned RELOCK_CYC  = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  input  logic       set_code,
  output logic       lock,
  output logic       lockout,
  output logic       err,
  output logic [1:0] fail_cnt,
  output logic [2:0] digit_cnt
);

  localparam int unsigned TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int unsigned TW   = $clog2(TMAX);

  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0] RELOCK_LOAD  = TW'(RELOCK_CYC - 1);
  localparam logic [1:0]    FAIL_LIMIT   = 2'(MAX_FAIL);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_UNLOCKED,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_e;

  state_e        state_q, state_d;
  logic [9:0]    tenkey_q, tenkey_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   code_q, code_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d;
  logic          lock_q, lock_d;
  logic          lockout_q, lockout_d;
  logic          err_q, err_d;
  logic [TW-1:0] timer_q, timer_d;

  logic          key_onehot;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic [15:0]   buf_shift;
  logic [1:0]    fail_next;

  // A press counts only on the first cycle of a clean single-key contact.
  always_comb begin
    key_onehot = (tenkey != '0) && ((tenkey & (tenkey - 10'd1)) == '0);
    key_valid  = key_onehot && (tenkey_q == '0);
    key_digit  = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (tenkey[i]) key_digit = 4'(i);
    end
    buf_shift = {buf_q[11:0], key_digit};
    fail_next = fail_cnt_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    tenkey_d    = tenkey;
    buf_d       = buf_q;
    code_d      = code_q;
    digit_cnt_d = digit_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    lock_d      = lock_q;
    lockout_d   = lockout_q;
    err_d       = 1'b0;
    timer_d     = timer_q;

    case (state_q)
      ST_IDLE: begin
        lock_d = 1'b1;
        if (close) begin
          buf_d       = '0;
          digit_cnt_d = '0;
        end else if (key_valid) begin
          buf_d       = buf_shift;
          digit_cnt_d = digit_cnt_q + 3'd1;
          if (digit_cnt_q == 3'd3) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        buf_d       = '0;
        digit_cnt_d = '0;
        if (buf_q == code_q) begin
          state_d    = ST_UNLOCKED;
          lock_d     = 1'b0;
          fail_cnt_d = '0;
          timer_d    = RELOCK_LOAD;
        end else begin
          err_d      = 1'b1;
          fail_cnt_d = fail_next;
          if (fail_next == FAIL_LIMIT) begin
            state_d   = ST_LOCKOUT;
            lockout_d = 1'b1;
            timer_d   = LOCKOUT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_UNLOCKED: begin
        // close beats timer expiry, and expiry beats a program request
        if (close || (timer_q == '0)) begin
          state_d = ST_IDLE;
          lock_d  = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
          if (set_code) begin
            state_d     = ST_PROGRAM;
            buf_d       = '0;
            digit_cnt_d = '0;
          end
        end
      end

      ST_PROGRAM: begin
        if (close) begin
          state_d     = ST_IDLE;
          lock_d      = 1'b1;
          buf_d       = '0;
          digit_cnt_d = '0;
        end else if (key_valid) begin
          buf_d       = buf_shift;
          digit_cnt_d = digit_cnt_q + 3'd1;
          if (digit_cnt_q == 3'd3) begin
            code_d      = buf_shift;
            buf_d       = '0;
            digit_cnt_d = '0;
            state_d     = ST_UNLOCKED;
            timer_d     = RELOCK_LOAD;
          end
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d    = ST_IDLE;
          lockout_d  = 1'b0;
          fail_cnt_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        lock_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tenkey_q    <= '0;
      buf_q       <= '0;
      code_q      <= DEF_CODE;
      digit_cnt_q <= '0;
      fail_cnt_q  <= '0;
      lock_q      <= 1'b1;
      lockout_q   <= 1'b0;
      err_q       <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      tenkey_q    <= tenkey_d;
      buf_q       <= buf_d;
      code_q      <= code_d;
      digit_cnt_q <= digit_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      lock_q      <= lock_d;
      lockout_q   <= lockout_d;
      err_q       <= err_d;
      timer_q     <= timer_d;
    end
  end

  assign lock      = lock_q;
  assign lockout   = lockout_q;
  assign err       = err_q;
  assign fail_cnt  = fail_cnt_q;
  assign digit_cnt = digit_cnt_q;

endmodule
